sync_fifo_read_port: RTL

// Read side of the systolic-array synchronous FIFO. It sits downstream of the write pointer.
// It consumes w_ptr and returns r_ptr to the write pointer, which uses it for full detection.
// It issues reads to the synchronous-read storage array (1-cycle read latency).

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_out_buf.sv | 87 ++++++++
 rtl/sync_fifo_read_port.sv | 65 ++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing for the synchronous FIFO read and write stages.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam int OUT_BUF_DEPTH = 2;

    // Pointer carries one wrap bit above the storage address so full and empty differ.
    function automatic int ptr_w(input int entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_out_buf.sv
// Two-entry output buffer with head at entry 0; write lands the cycle after a storage read.
// deq_val/deq_msg are registered; msg holds while the consumer stalls.
module sync_fifo_out_buf
    import sync_fifo_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic             val,
    output logic [width-1:0] msg,
    output logic [1:0]       cnt
);

    buf_state_e       state;
    buf_state_e       state_next;
    logic [width-1:0] entry [OUT_BUF_DEPTH];
    logic             head_load;
    logic             tail_load;
    logic             head_from_tail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        tail_load      = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (wr) begin
                    state_next = BUF_ONE;
                    head_load  = 1'b1;
                end
            end
            BUF_ONE: begin
                if (wr && !pop) begin
                    state_next = BUF_TWO;
                    tail_load  = 1'b1;
                end else if (!wr && pop) begin
                    state_next = BUF_EMPTY;
                end else if (wr && pop) begin
                    head_load = 1'b1;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_from_tail = 1'b1;
                    if (wr) begin
                        tail_load = 1'b1;
                    end else begin
                        state_next = BUF_ONE;
                    end
                end
            end
            default: state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (head_load) begin
            entry[0] <= wdata;
        end else if (head_from_tail) begin
            entry[0] <= entry[1];
        end
        if (tail_load) begin
            entry[1] <= wdata;
        end
    end

    // The issue rule never lets a word arrive into a full, stalled buffer.
    assert property (@(posedge clk) disable iff (!rst) !(state == BUF_TWO && wr && !pop));

    assign val = (state != BUF_EMPTY);
    assign msg = entry[0];
    assign cnt = state;

endmodule

// File: rtl/sync_fifo_read_port.sv
// Read side of the synchronous FIFO: issues storage reads, buffers two words, serves val/rdy.
// First word reaches deq_val two cycles after w_ptr advances; deq_rdy low stops reads after two.
module sync_fifo_read_port
    import sync_fifo_pkg::*;
#(
    parameter int depth     = 16,
    parameter int width     = 32,
    parameter int ptr_width = ptr_w(depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ptr_width-1:0] w_ptr,
    output logic [ptr_width-1:0] r_ptr,
    output logic                 ren,
    output logic [ptr_width-2:0] raddr,
    input  logic [width-1:0]     rdata,
    output logic                 deq_val,
    input  logic                 deq_rdy,
    output logic [width-1:0]     deq_msg,
    output logic [ptr_width:0]   occupancy
);

    logic                 inflight;
    logic                 mem_empty;
    logic                 fire;
    logic [1:0]           buf_cnt;
    logic [1:0]           pending;
    logic [ptr_width-1:0] ptr_diff;

    assign mem_empty = (r_ptr == w_ptr);
    assign fire      = deq_val & deq_rdy;
    assign pending   = buf_cnt + {1'b0, inflight};

    // A pop this cycle frees the slot the word issued now will need, so reads run back-to-back.
    assign ren   = rst & ~mem_empty & ((pending < 2'(OUT_BUF_DEPTH)) | fire);
    assign raddr = r_ptr[ptr_width-2:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= '0;
            inflight <= 1'b0;
        end else begin
            r_ptr    <= r_ptr + ptr_width'(ren);
            inflight <= ren;
        end
    end

    sync_fifo_out_buf #(
        .width(width)
    ) u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .wr    (inflight),
        .wdata (rdata),
        .pop   (fire),
        .val   (deq_val),
        .msg   (deq_msg),
        .cnt   (buf_cnt)
    );

    assign ptr_diff  = w_ptr - r_ptr;
    assign occupancy = (ptr_width+1)'(ptr_diff) + (ptr_width+1)'(inflight)
                     + (ptr_width+1)'(buf_cnt);

endmodule
